// File: rtl/taxi_axi_axil_adapter_rd.sv
// AXI4 read burst to single-beat AXI-Lite read adapter with data width conversion.
// Optional `TAXI_AXI_AXIL_RD_4K_CHECK_EN: beats leaving the burst's 4 KiB page return SLVERR without a read.
module taxi_axi_axil_adapter_rd #(
  parameter int AXI_DATA_W  = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = 16,
  parameter int ID_W        = 8,
  parameter bit ARUSER_EN   = 1'b0,
  parameter bit RUSER_EN    = 1'b0,
  parameter int ARUSER_W    = 1,
  parameter int RUSER_W     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_W-1:0]        s_axi_arid_i,
  input  logic [ADDR_W-1:0]      s_axi_araddr_i,
  input  logic [7:0]             s_axi_arlen_i,
  input  logic [2:0]             s_axi_arsize_i,
  input  logic [1:0]             s_axi_arburst_i,
  input  logic [2:0]             s_axi_arprot_i,
  input  logic [ARUSER_W-1:0]    s_axi_aruser_i,
  input  logic                   s_axi_arvalid_i,
  output logic                   s_axi_arready_o,
  output logic [ID_W-1:0]        s_axi_rid_o,
  output logic [AXI_DATA_W-1:0]  s_axi_rdata_o,
  output logic [1:0]             s_axi_rresp_o,
  output logic                   s_axi_rlast_o,
  output logic [RUSER_W-1:0]     s_axi_ruser_o,
  output logic                   s_axi_rvalid_o,
  input  logic                   s_axi_rready_i,
  output logic [ADDR_W-1:0]      m_axil_araddr_o,
  output logic [2:0]             m_axil_arprot_o,
  output logic [ARUSER_W-1:0]    m_axil_aruser_o,
  output logic                   m_axil_arvalid_o,
  input  logic                   m_axil_arready_i,
  input  logic [AXIL_DATA_W-1:0] m_axil_rdata_i,
  input  logic [1:0]             m_axil_rresp_i,
  input  logic [RUSER_W-1:0]     m_axil_ruser_i,
  input  logic                   m_axil_rvalid_i,
  output logic                   m_axil_rready_o
);

  localparam int AXI_STRB_W  = AXI_DATA_W / 8;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;
  localparam int AXI_OFF     = $clog2(AXI_STRB_W);
  localparam int AXIL_OFF    = $clog2(AXIL_STRB_W);
  localparam logic [2:0] MAX_SIZE = 3'(AXI_OFF);
  localparam logic [ADDR_W-1:0] LITE_MASK = ~ADDR_W'(AXIL_STRB_W - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  arready_q, m_arvalid_q, m_rready_q, s_rvalid_q;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     lite_addr_q, lite_addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            prot_q, prot_d;
  logic [ARUSER_W-1:0]   aruser_q, aruser_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            seg_left_q, seg_left_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [RUSER_W-1:0]    ruser_q, ruser_d;
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
  logic [ADDR_W-1:0]     start_addr_q, start_addr_d;
`endif

  logic [2:0]            arsize_clamp;
  logic [ADDR_W-1:0]     size_bytes, wrap_mask, incr_addr, next_addr;
  logic [AXI_DATA_W-1:0] beat_data;

  // Extra AXI-Lite reads needed after the first one to cover a beat of 2^size bytes.
  function automatic logic [7:0] seg_left_f(input logic [2:0] size);
    if (int'(size) > AXIL_OFF) return 8'((1 << (int'(size) - AXIL_OFF)) - 1);
    return 8'd0;
  endfunction

  assign arsize_clamp = (s_axi_arsize_i > MAX_SIZE) ? MAX_SIZE : s_axi_arsize_i;
  assign size_bytes   = ADDR_W'(1) << size_q;
  assign wrap_mask    = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign incr_addr    = (addr_q & ~(size_bytes - ADDR_W'(1))) + size_bytes;

  always_comb begin
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  generate
    if (AXIL_DATA_W == AXI_DATA_W) begin : g_same
      assign beat_data = m_axil_rdata_i;
    end else if (AXIL_DATA_W > AXI_DATA_W) begin : g_wide
      logic [AXIL_OFF-AXI_OFF-1:0] lane;
      assign lane      = addr_q[AXIL_OFF-1:AXI_OFF];
      assign beat_data = m_axil_rdata_i[lane*AXI_DATA_W +: AXI_DATA_W];
    end else begin : g_narrow
      localparam int SEG_N = AXI_DATA_W / AXIL_DATA_W;
      localparam int SEG_W = AXI_OFF - AXIL_OFF;
      logic [SEG_W-1:0] seg;
      assign seg = lite_addr_q[AXI_OFF-1:AXIL_OFF];
      // Only the segment being returned is replaced; the rest keep earlier reads (or zero).
      for (genvar gi = 0; gi < SEG_N; gi++) begin : g_seg
        assign beat_data[gi*AXIL_DATA_W +: AXIL_DATA_W] = (seg == SEG_W'(gi)) ?
            m_axil_rdata_i : rdata_q[gi*AXIL_DATA_W +: AXIL_DATA_W];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    lite_addr_d = lite_addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    prot_d      = prot_q;
    aruser_d    = aruser_q;
    beat_d      = beat_q;
    seg_left_d  = seg_left_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    ruser_d     = ruser_q;
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
    start_addr_d = start_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_axi_arvalid_i && arready_q) begin
          id_d        = s_axi_arid_i;
          addr_d      = s_axi_araddr_i;
          lite_addr_d = s_axi_araddr_i & LITE_MASK;
          len_d       = s_axi_arlen_i;
          size_d      = arsize_clamp;
          burst_d     = s_axi_arburst_i;
          prot_d      = s_axi_arprot_i;
          aruser_d    = s_axi_aruser_i;
          beat_d      = 8'd0;
          seg_left_d  = seg_left_f(arsize_clamp);
          rdata_d     = '0;
          rresp_d     = 2'b00;
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
          start_addr_d = s_axi_araddr_i;
`endif
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (m_axil_arready_i && m_arvalid_q) state_d = DATA;
      end
      DATA: begin
        if (m_axil_rvalid_i && m_rready_q) begin
          rdata_d = beat_data;
          rresp_d = (m_axil_rresp_i > rresp_q) ? m_axil_rresp_i : rresp_q;
          ruser_d = m_axil_ruser_i;
          if (seg_left_q != 8'd0) begin
            seg_left_d  = seg_left_q - 8'd1;
            lite_addr_d = lite_addr_q + ADDR_W'(AXIL_STRB_W);
            state_d     = ADDR;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (s_axi_rready_i && s_rvalid_q) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d      = beat_q + 8'd1;
            addr_d      = next_addr;
            lite_addr_d = next_addr & LITE_MASK;
            seg_left_d  = seg_left_f(size_q);
            rdata_d     = '0;
            rresp_d     = 2'b00;
            state_d     = ADDR;
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
            // Beat outside the starting page: answer locally instead of reading.
            if (next_addr[ADDR_W-1:12] != start_addr_q[ADDR_W-1:12]) begin
              rresp_d = 2'b10;
              state_d = RESP;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      s_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= (state_d == IDLE);
      m_arvalid_q <= (state_d == ADDR);
      m_rready_q  <= (state_d == DATA);
      s_rvalid_q  <= (state_d == RESP);
    end
  end

  always_ff @(posedge clk) begin
    id_q        <= id_d;
    addr_q      <= addr_d;
    lite_addr_q <= lite_addr_d;
    len_q       <= len_d;
    size_q      <= size_d;
    burst_q     <= burst_d;
    prot_q      <= prot_d;
    aruser_q    <= aruser_d;
    beat_q      <= beat_d;
    seg_left_q  <= seg_left_d;
    rdata_q     <= rdata_d;
    rresp_q     <= rresp_d;
    ruser_q     <= ruser_d;
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
    start_addr_q <= start_addr_d;
`endif
  end

  assign s_axi_arready_o  = arready_q;
  assign s_axi_rid_o      = id_q;
  assign s_axi_rdata_o    = rdata_q;
  assign s_axi_rresp_o    = rresp_q;
  assign s_axi_rlast_o    = s_rvalid_q && (beat_q == len_q);
  assign s_axi_ruser_o    = RUSER_EN ? ruser_q : '0;
  assign s_axi_rvalid_o   = s_rvalid_q;
  assign m_axil_araddr_o  = lite_addr_q;
  assign m_axil_arprot_o  = prot_q;
  assign m_axil_aruser_o  = ARUSER_EN ? aruser_q : '0;
  assign m_axil_arvalid_o = m_arvalid_q;
  assign m_axil_rready_o  = m_rready_q;

endmodule

// File: tb/tb_taxi_axi_axil_adapter_rd.sv
// Directed bench: 32/32 instance (a_) and 64/32 instance (b_), each with a small AXI-Lite slave returning data = address.
module tb_taxi_axi_axil_adapter_rd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A: 32/32 ----------------
  logic [3:0]  a_s_arid;
  logic [15:0] a_s_araddr;
  logic [7:0]  a_s_arlen;
  logic [2:0]  a_s_arsize;
  logic [1:0]  a_s_arburst;
  logic [2:0]  a_s_arprot;
  logic [0:0]  a_s_aruser;
  logic        a_s_arvalid, a_s_arready;
  logic [3:0]  a_s_rid;
  logic [31:0] a_s_rdata;
  logic [1:0]  a_s_rresp;
  logic        a_s_rlast;
  logic [0:0]  a_s_ruser;
  logic        a_s_rvalid, a_s_rready;
  logic [15:0] a_m_araddr;
  logic [2:0]  a_m_arprot;
  logic [0:0]  a_m_aruser;
  logic        a_m_arvalid, a_m_arready;
  logic [31:0] a_m_rdata;
  logic [1:0]  a_m_rresp;
  logic [0:0]  a_m_ruser;
  logic        a_m_rvalid, a_m_rready;

  taxi_axi_axil_adapter_rd #(
    .AXI_DATA_W(32), .AXIL_DATA_W(32), .ADDR_W(16), .ID_W(4)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .s_axi_arid_i(a_s_arid), .s_axi_araddr_i(a_s_araddr), .s_axi_arlen_i(a_s_arlen),
    .s_axi_arsize_i(a_s_arsize), .s_axi_arburst_i(a_s_arburst), .s_axi_arprot_i(a_s_arprot),
    .s_axi_aruser_i(a_s_aruser), .s_axi_arvalid_i(a_s_arvalid), .s_axi_arready_o(a_s_arready),
    .s_axi_rid_o(a_s_rid), .s_axi_rdata_o(a_s_rdata), .s_axi_rresp_o(a_s_rresp),
    .s_axi_rlast_o(a_s_rlast), .s_axi_ruser_o(a_s_ruser), .s_axi_rvalid_o(a_s_rvalid),
    .s_axi_rready_i(a_s_rready),
    .m_axil_araddr_o(a_m_araddr), .m_axil_arprot_o(a_m_arprot), .m_axil_aruser_o(a_m_aruser),
    .m_axil_arvalid_o(a_m_arvalid), .m_axil_arready_i(a_m_arready),
    .m_axil_rdata_i(a_m_rdata), .m_axil_rresp_i(a_m_rresp), .m_axil_ruser_i(a_m_ruser),
    .m_axil_rvalid_i(a_m_rvalid), .m_axil_rready_o(a_m_rready)
  );

  // ---------------- instance B: 64/32 ----------------
  logic [3:0]  b_s_arid;
  logic [15:0] b_s_araddr;
  logic [7:0]  b_s_arlen;
  logic [2:0]  b_s_arsize;
  logic [1:0]  b_s_arburst;
  logic [2:0]  b_s_arprot;
  logic [0:0]  b_s_aruser;
  logic        b_s_arvalid, b_s_arready;
  logic [3:0]  b_s_rid;
  logic [63:0] b_s_rdata;
  logic [1:0]  b_s_rresp;
  logic        b_s_rlast;
  logic [0:0]  b_s_ruser;
  logic        b_s_rvalid, b_s_rready;
  logic [15:0] b_m_araddr;
  logic [2:0]  b_m_arprot;
  logic [0:0]  b_m_aruser;
  logic        b_m_arvalid, b_m_arready;
  logic [31:0] b_m_rdata;
  logic [1:0]  b_m_rresp;
  logic [0:0]  b_m_ruser;
  logic        b_m_rvalid, b_m_rready;

  taxi_axi_axil_adapter_rd #(
    .AXI_DATA_W(64), .AXIL_DATA_W(32), .ADDR_W(16), .ID_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axi_arid_i(b_s_arid), .s_axi_araddr_i(b_s_araddr), .s_axi_arlen_i(b_s_arlen),
    .s_axi_arsize_i(b_s_arsize), .s_axi_arburst_i(b_s_arburst), .s_axi_arprot_i(b_s_arprot),
    .s_axi_aruser_i(b_s_aruser), .s_axi_arvalid_i(b_s_arvalid), .s_axi_arready_o(b_s_arready),
    .s_axi_rid_o(b_s_rid), .s_axi_rdata_o(b_s_rdata), .s_axi_rresp_o(b_s_rresp),
    .s_axi_rlast_o(b_s_rlast), .s_axi_ruser_o(b_s_ruser), .s_axi_rvalid_o(b_s_rvalid),
    .s_axi_rready_i(b_s_rready),
    .m_axil_araddr_o(b_m_araddr), .m_axil_arprot_o(b_m_arprot), .m_axil_aruser_o(b_m_aruser),
    .m_axil_arvalid_o(b_m_arvalid), .m_axil_arready_i(b_m_arready),
    .m_axil_rdata_i(b_m_rdata), .m_axil_rresp_i(b_m_rresp), .m_axil_ruser_i(b_m_ruser),
    .m_axil_rvalid_i(b_m_rvalid), .m_axil_rready_o(b_m_rready)
  );

  // ---------------- AXI-Lite slave models ----------------
  logic        a_busy, b_busy;
  logic [15:0] b_err_addr = 16'hFFFF;
  logic [15:0] a_lite[$];
  logic [15:0] b_lite[$];

  assign a_m_arready = !a_busy;
  assign b_m_arready = !b_busy;
  assign a_m_ruser   = 1'b0;
  assign b_m_ruser   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      a_busy <= 1'b0; a_m_rvalid <= 1'b0; a_m_rdata <= '0; a_m_rresp <= 2'b00;
    end else begin
      if (a_m_arvalid && a_m_arready) begin
        a_busy <= 1'b1; a_m_rvalid <= 1'b1;
        a_m_rdata <= 32'(a_m_araddr); a_m_rresp <= 2'b00;
        a_lite.push_back(a_m_araddr);
      end
      if (a_m_rvalid && a_m_rready) begin
        a_busy <= 1'b0; a_m_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      b_busy <= 1'b0; b_m_rvalid <= 1'b0; b_m_rdata <= '0; b_m_rresp <= 2'b00;
    end else begin
      if (b_m_arvalid && b_m_arready) begin
        b_busy <= 1'b1; b_m_rvalid <= 1'b1;
        b_m_rdata <= 32'(b_m_araddr);
        b_m_rresp <= (b_m_araddr == b_err_addr) ? 2'b10 : 2'b00;
        b_lite.push_back(b_m_araddr);
      end
      if (b_m_rvalid && b_m_rready) begin
        b_busy <= 1'b0; b_m_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- R beat monitors ----------------
  logic [31:0] a_data[$];
  logic [1:0]  a_resp[$];
  logic        a_last[$];
  logic [3:0]  a_id[$];
  logic [63:0] b_data[$];
  logic [1:0]  b_resp[$];
  logic        b_last[$];

  always @(posedge clk) begin
    if (!rst && a_s_rvalid && a_s_rready) begin
      a_data.push_back(a_s_rdata); a_resp.push_back(a_s_rresp);
      a_last.push_back(a_s_rlast); a_id.push_back(a_s_rid);
      $display("beat A id=%0h data=%h resp=%0d last=%0b", a_s_rid, a_s_rdata, a_s_rresp, a_s_rlast);
    end
    if (!rst && b_s_rvalid && b_s_rready) begin
      b_data.push_back(b_s_rdata); b_resp.push_back(b_s_rresp); b_last.push_back(b_s_rlast);
      $display("beat B id=%0h data=%h resp=%0d last=%0b", b_s_rid, b_s_rdata, b_s_rresp, b_s_rlast);
    end
  end

  task automatic clear_a();
    a_lite.delete(); a_data.delete(); a_resp.delete(); a_last.delete(); a_id.delete();
  endtask

  task automatic issue_a(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    a_s_arid = id; a_s_araddr = addr; a_s_arlen = len; a_s_arsize = size; a_s_arburst = burst;
    a_s_arvalid = 1'b1;
    while (a_s_arready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL issue_a arready actual=%0b required=1", a_s_arready); end
    @(posedge clk); #1;
    a_s_arvalid = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    b_s_arid = id; b_s_araddr = addr; b_s_arlen = len; b_s_arsize = size; b_s_arburst = burst;
    b_s_arvalid = 1'b1;
    while (b_s_arready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL issue_b arready actual=%0b required=1", b_s_arready); end
    @(posedge clk); #1;
    b_s_arvalid = 1'b0;
  endtask

  task automatic wait_a(input int nbeats, input int limit);
    int c = 0;
    while (a_data.size() < nbeats && c < limit) begin @(posedge clk); #1; c++; end
    total++;
    if (a_data.size() < nbeats) begin
      bad++; $display("FAIL wait_a beats actual=%0d required=%0d", a_data.size(), nbeats);
    end
  endtask

  task automatic wait_b(input int nbeats, input int limit);
    int c = 0;
    while (b_data.size() < nbeats && c < limit) begin @(posedge clk); #1; c++; end
    total++;
    if (b_data.size() < nbeats) begin
      bad++; $display("FAIL wait_b beats actual=%0d required=%0d", b_data.size(), nbeats);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_s_arready !== 1'b0) begin bad++; $display("FAIL rst_arready actual=%0b required=0", a_s_arready); end
    total++; if (a_s_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid actual=%0b required=0", a_s_rvalid); end
    total++; if (a_s_rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast actual=%0b required=0", a_s_rlast); end
    total++; if (a_m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_m_arvalid actual=%0b required=0", a_m_arvalid); end
    total++; if (a_m_rready !== 1'b0) begin bad++; $display("FAIL rst_m_rready actual=%0b required=0", a_m_rready); end
    total++; if (b_s_arready !== 1'b0) begin bad++; $display("FAIL rst_b_arready actual=%0b required=0", b_s_arready); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (a_s_arready !== 1'b1) begin bad++; $display("FAIL post_rst_arready actual=%0b required=1", a_s_arready); end
  endtask

  task automatic test_incr();
    clear_a();
    issue_a(4'h5, 16'h0100, 8'd3, 3'd2, 2'b01);
    total++; if (a_m_arvalid !== 1'b1) begin bad++; $display("FAIL incr_ar_latency actual=%0b required=1", a_m_arvalid); end
    wait_a(4, 200);
    total++; if (a_lite.size() !== 4) begin bad++; $display("FAIL incr_nreads actual=%0d required=4", a_lite.size()); end
    for (int i = 0; i < 4 && i < a_data.size() && i < a_lite.size(); i++) begin
      total++; if (a_lite[i] !== 16'h0100 + 16'(4*i)) begin bad++; $display("FAIL incr_addr%0d actual=%h required=%h", i, a_lite[i], 16'h0100 + 16'(4*i)); end
      total++; if (a_data[i] !== 32'h0100 + 32'(4*i)) begin bad++; $display("FAIL incr_data%0d actual=%h required=%h", i, a_data[i], 32'h0100 + 32'(4*i)); end
      total++; if (a_last[i] !== (i == 3)) begin bad++; $display("FAIL incr_last%0d actual=%0b required=%0b", i, a_last[i], i == 3); end
      total++; if (a_id[i] !== 4'h5) begin bad++; $display("FAIL incr_id%0d actual=%h required=5", i, a_id[i]); end
      total++; if (a_resp[i] !== 2'b00) begin bad++; $display("FAIL incr_resp%0d actual=%0d required=0", i, a_resp[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4] = '{16'h38, 16'h3C, 16'h30, 16'h34};
    clear_a();
    issue_a(4'h1, 16'h0038, 8'd3, 3'd2, 2'b10);
    wait_a(4, 200);
    total++; if (a_lite.size() !== 4) begin bad++; $display("FAIL wrap_nreads actual=%0d required=4", a_lite.size()); end
    for (int i = 0; i < 4 && i < a_data.size() && i < a_lite.size(); i++) begin
      total++; if (a_lite[i] !== exp_addr[i]) begin bad++; $display("FAIL wrap_addr%0d actual=%h required=%h", i, a_lite[i], exp_addr[i]); end
      total++; if (a_data[i] !== 32'(exp_addr[i])) begin bad++; $display("FAIL wrap_data%0d actual=%h required=%h", i, a_data[i], exp_addr[i]); end
    end
  endtask

  task automatic test_fixed_stall();
    clear_a();
    a_s_rready = 1'b0;
    issue_a(4'h2, 16'h0020, 8'd2, 3'd2, 2'b00);
    for (int b = 0; b < 3; b++) begin
      int c = 0;
      while (a_s_rvalid !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
      total++; if (a_s_rvalid !== 1'b1) begin bad++; $display("FAIL fixed_rvalid%0d actual=%0b required=1", b, a_s_rvalid); end
      for (int k = 0; k < 5; k++) begin
        total++; if (a_s_rdata !== 32'h20) begin bad++; $display("FAIL fixed_hold_data%0d actual=%h required=00000020", b, a_s_rdata); end
        total++; if (a_lite.size() !== b + 1) begin bad++; $display("FAIL fixed_hold_reads%0d actual=%0d required=%0d", b, a_lite.size(), b + 1); end
        total++; if (a_m_rready !== 1'b0) begin bad++; $display("FAIL fixed_hold_m_rready%0d actual=%0b required=0", b, a_m_rready); end
        @(posedge clk); #1;
      end
      total++; if (a_s_rlast !== (b == 2)) begin bad++; $display("FAIL fixed_last%0d actual=%0b required=%0b", b, a_s_rlast, b == 2); end
      a_s_rready = 1'b1;
      @(posedge clk); #1;
      a_s_rready = 1'b0;
    end
    a_s_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_data.size() !== 3) begin bad++; $display("FAIL fixed_nbeats actual=%0d required=3", a_data.size()); end
    for (int i = 0; i < a_lite.size(); i++) begin
      total++; if (a_lite[i] !== 16'h0020) begin bad++; $display("FAIL fixed_addr%0d actual=%h required=0020", i, a_lite[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_a();
    issue_a(4'h3, 16'h0200, 8'd3, 3'd2, 2'b01);
    while (!(a_m_arvalid === 1'b1 && a_data.size() == 1) && c < 100) begin @(posedge clk); #1; c++; end
    total++; if (c >= 100) begin bad++; $display("FAIL mid_reach_addr1 actual=timeout required=beat1 ADDR"); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (a_m_arvalid !== 1'b0) begin bad++; $display("FAIL mid_m_arvalid actual=%0b required=0", a_m_arvalid); end
    total++; if (a_s_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid actual=%0b required=0", a_s_rvalid); end
    total++; if (a_m_rready !== 1'b0) begin bad++; $display("FAIL mid_m_rready actual=%0b required=0", a_m_rready); end
    total++; if (a_s_arready !== 1'b0) begin bad++; $display("FAIL mid_arready actual=%0b required=0", a_s_arready); end
    total++; if (a_lite.size() !== 1) begin bad++; $display("FAIL mid_nreads actual=%0d required=1", a_lite.size()); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_a();
    issue_a(4'h4, 16'h0300, 8'd1, 3'd2, 2'b01);
    wait_a(2, 100);
    if (a_data.size() >= 2) begin
      total++; if (a_data[0] !== 32'h300) begin bad++; $display("FAIL after_rst_data0 actual=%h required=00000300", a_data[0]); end
      total++; if (a_data[1] !== 32'h304) begin bad++; $display("FAIL after_rst_data1 actual=%h required=00000304", a_data[1]); end
      total++; if (a_last[1] !== 1'b1) begin bad++; $display("FAIL after_rst_last actual=%0b required=1", a_last[1]); end
      total++; if (a_id[1] !== 4'h4) begin bad++; $display("FAIL after_rst_id actual=%h required=4", a_id[1]); end
    end
  endtask

  task automatic test_width();
    logic [15:0] exp_addr [4] = '{16'h08, 16'h0C, 16'h10, 16'h14};
    b_err_addr = 16'h000C;
    issue_b(4'h3, 16'h0008, 8'd1, 3'd3, 2'b01);
    wait_b(2, 200);
    total++; if (b_lite.size() !== 4) begin bad++; $display("FAIL width_nreads actual=%0d required=4", b_lite.size()); end
    for (int i = 0; i < 4 && i < b_lite.size(); i++) begin
      total++; if (b_lite[i] !== exp_addr[i]) begin bad++; $display("FAIL width_addr%0d actual=%h required=%h", i, b_lite[i], exp_addr[i]); end
    end
    if (b_data.size() >= 2) begin
      total++; if (b_data[0] !== 64'h0000000C_00000008) begin bad++; $display("FAIL width_data0 actual=%h required=0000000c00000008", b_data[0]); end
      total++; if (b_resp[0] !== 2'b10) begin bad++; $display("FAIL width_resp0 actual=%0d required=2", b_resp[0]); end
      total++; if (b_last[0] !== 1'b0) begin bad++; $display("FAIL width_last0 actual=%0b required=0", b_last[0]); end
      total++; if (b_data[1] !== 64'h00000014_00000010) begin bad++; $display("FAIL width_data1 actual=%h required=0000001400000010", b_data[1]); end
      total++; if (b_resp[1] !== 2'b00) begin bad++; $display("FAIL width_resp1 actual=%0d required=0", b_resp[1]); end
      total++; if (b_last[1] !== 1'b1) begin bad++; $display("FAIL width_last1 actual=%0b required=1", b_last[1]); end
    end
    // Narrow beat on the wide port: only the upper word is fetched, lower lanes read zero.
    b_lite.delete(); b_data.delete(); b_resp.delete(); b_last.delete();
    issue_b(4'h6, 16'h0024, 8'd0, 3'd2, 2'b01);
    wait_b(1, 100);
    total++; if (b_lite.size() !== 1) begin bad++; $display("FAIL narrow_nreads actual=%0d required=1", b_lite.size()); end
    if (b_data.size() >= 1) begin
      total++; if (b_data[0] !== 64'h00000024_00000000) begin bad++; $display("FAIL narrow_data actual=%h required=0000002400000000", b_data[0]); end
      total++; if (b_last[0] !== 1'b1) begin bad++; $display("FAIL narrow_last actual=%0b required=1", b_last[0]); end
    end
  endtask

  task automatic test_4k();
`ifdef TAXI_AXI_AXIL_RD_4K_CHECK_EN
    logic [31:0] exp_data [4] = '{32'hFF8, 32'hFFC, 32'h0, 32'h0};
    logic [1:0]  exp_resp [4] = '{2'b00, 2'b00, 2'b10, 2'b10};
    int          exp_reads = 2;
`else
    logic [31:0] exp_data [4] = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
    logic [1:0]  exp_resp [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    int          exp_reads = 4;
`endif
    clear_a();
    issue_a(4'h7, 16'h0FF8, 8'd3, 3'd2, 2'b01);
    wait_a(4, 200);
    total++; if (a_lite.size() !== exp_reads) begin bad++; $display("FAIL 4k_nreads actual=%0d required=%0d", a_lite.size(), exp_reads); end
    for (int i = 0; i < 4 && i < a_data.size(); i++) begin
      total++; if (a_data[i] !== exp_data[i]) begin bad++; $display("FAIL 4k_data%0d actual=%h required=%h", i, a_data[i], exp_data[i]); end
      total++; if (a_resp[i] !== exp_resp[i]) begin bad++; $display("FAIL 4k_resp%0d actual=%0d required=%0d", i, a_resp[i], exp_resp[i]); end
      total++; if (a_last[i] !== (i == 3)) begin bad++; $display("FAIL 4k_last%0d actual=%0b required=%0b", i, a_last[i], i == 3); end
    end
  endtask

  task automatic test_long_burst();
    int nlast = 0;
    int nbad_data = 0;
    clear_a();
    issue_a(4'h9, 16'h0040, 8'd255, 3'd2, 2'b00);
    wait_a(256, 3000);
    repeat (5) @(posedge clk);
    #1;
    total++; if (a_data.size() !== 256) begin bad++; $display("FAIL long_nbeats actual=%0d required=256", a_data.size()); end
    foreach (a_data[i]) begin
      if (a_last[i]) nlast++;
      if (a_data[i] !== 32'h40) nbad_data++;
    end
    total++; if (nlast !== 1) begin bad++; $display("FAIL long_nlast actual=%0d required=1", nlast); end
    total++; if (nbad_data !== 0) begin bad++; $display("FAIL long_data actual=%0d wrong beats required=0", nbad_data); end
    if (a_last.size() == 256) begin
      total++; if (a_last[255] !== 1'b1) begin bad++; $display("FAIL long_final_last actual=%0b required=1", a_last[255]); end
    end
  endtask

  initial begin
    a_s_arid = '0; a_s_araddr = '0; a_s_arlen = '0; a_s_arsize = '0; a_s_arburst = '0;
    a_s_arprot = '0; a_s_aruser = '0; a_s_arvalid = 1'b0; a_s_rready = 1'b1;
    b_s_arid = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0; b_s_arburst = '0;
    b_s_arprot = '0; b_s_aruser = '0; b_s_arvalid = 1'b0; b_s_rready = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_reset_mid();
    test_width();
    test_4k();
    test_long_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/taxi_axi_axil_adapter_rd.md
Name: taxi_axi_axil_adapter_rd

Overview:
- Converts AXI4 read bursts on a full AXI4 slave port into a sequence of single-beat AXI4-Lite reads on a master port.
- Lets full-AXI initiators (DMA engines, interconnect masters) reach AXI-Lite register blocks.
- Performs data width conversion when the two data widths differ.
- Exactly one AXI-Lite read is outstanding at any time.

Parameters:
- AXI_DATA_W, from s_axi_rd.DATA_W: AXI data width. Byte lanes must be a power of two.
- AXIL_DATA_W, from m_axil_rd.DATA_W: AXI-Lite data width. Byte lanes must be a power of two. Byte size must equal the AXI byte size, else $fatal.
- ADDR_W, from s_axi_rd.ADDR_W: address width. Shared by both ports.
- ID_W, from s_axi_rd.ID_W: ID width.
- ARUSER_EN / RUSER_EN: AND of both interfaces' flags. When 0, the user output is driven to '0.

Ports:
- clk  input  1  clock
- rst  input  1  reset. Synchronous, active-high.
- s_axi_rd  taxi_axi_if.rd_slv  interface  AXI4 read slave (AR, R channels)
- m_axil_rd  taxi_axil_if.rd_mst  interface  AXI-Lite read master (AR, R channels)

Behaviour:
- Reset values: s_axi arready=0, rvalid=0, rlast=0. m_axil arvalid=0, rready=0. State=IDLE. Reset may be asserted mid-burst: the burst is abandoned and no further beats are produced. The downstream slave shares this reset.
- State machine states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - arready=1 the cycle after reset deasserts.
  - On the AR handshake, capture arid, araddr, arlen, arsize, arburst, arprot, aruser.
  - Clamp arsize to log2(AXI_STRB_W). Go to ADDR; m_axil arvalid asserts the next cycle.
- Reads per AXI beat: R = max(1, 2^size / AXIL_STRB_W).
  - First AXI-Lite address = beat address aligned down to the AXI-Lite width.
  - Each following read adds AXIL_STRB_W to the address.
  - m_axil arprot and aruser come from the captured values.
- ADDR: hold m_axil arvalid until arready. Then go to DATA with m_axil rready=1.
- DATA, on each AXI-Lite R handshake:
  - AXIL_DATA_W >= AXI_DATA_W: the AXI beat data is AXIL rdata lanes [addr[AXIL_OFF-1:AXI_OFF]].
  - AXIL_DATA_W < AXI_DATA_W: write the response into segment addr[AXI_OFF-1:AXIL_OFF] of the beat buffer. Lanes not fetched read as zero.
  - Merged rresp = maximum of the segment rresp codes (OKAY<SLVERR<DECERR).
  - ruser = last segment's ruser.
  - If segment reads remain: go back to ADDR. Otherwise go to RESP; s_axi rvalid asserts the next cycle.
- RESP:
  - Drive rid = captured ID. rlast=1 when beat count == arlen.
  - Hold rdata, rresp, rlast stable until rready.
  - m_axil rready stays 0 while s_axi rvalid is pending.
  - On the final beat's handshake go to IDLE. arready=1 the following cycle.
  - Otherwise advance the address and go to ADDR.
- Address advance:
  - FIXED: unchanged.
  - INCR: (addr aligned to 2^size) + 2^size. Wraps at the ADDR_W width.
  - WRAP: increment, then wrap within a (arlen+1)*2^size aligned window.
  - Reserved burst type 2'b11: treated as INCR.
- Minimum latency, bypass widths: AXI AR handshake cycle N -> AXI-Lite arvalid at N+1. AXI-Lite R handshake cycle M -> AXI rvalid at M+1.
- arlen=0 gives a single beat with rlast=1. arlen=255 gives 256 beats, with an 8-bit counter and no overflow.

Optional Feature:
- Macro: TAXI_AXI_AXIL_RD_4K_CHECK_EN.
- Defined: any beat whose address crosses the 4 KiB page of the burst start address issues no AXI-Lite read. That beat returns rdata=0 and rresp=SLVERR directly from RESP. rlast and beat count are unaffected.
- Undefined: addresses advance across 4 KiB boundaries with no check.

Test Plan:
- 32/32 bits, INCR, araddr=0x100, arlen=3, size=2, AXI-Lite data = address -> four AXI-Lite reads at 0x100/104/108/10C. rdata 0x100..0x10C. rlast on beat 3 only. rid echoes 0x5.
- AXI 64 / AXI-Lite 32 bits, araddr=0x8, arlen=1, size=3 -> reads at 0x8, 0xC, 0x10, 0x14. Beat 0 = {mem[0xC], mem[0x8]}. If the 0xC read returns SLVERR, beat 0 rresp=2.
- 32/32 bits, WRAP, araddr=0x38, arlen=3, size=2 -> reads at 0x38, 0x3C, 0x30, 0x34.
- FIXED, araddr=0x20, arlen=2 -> three reads at 0x20. AXI rready held low for 5 cycles per beat -> rdata stable, no extra AXI-Lite reads issued.
- Assert rst during the ADDR state of beat 1 -> all valids 0 the next cycle. A new burst after reset completes normally.
- With the macro defined: INCR araddr=0xFF8, arlen=3, size=2 -> reads only at 0xFF8 and 0xFFC. Beats 2 and 3 return SLVERR, rdata=0.
